muldiv_alu_control: RTL
=======================

// Module: muldiv_alu_control
// PURPOSE
//  RV32M-capable successor of the single-cycle ALU control decode. Decodes the full
//  32-bit instruction into the 11-bit alu_op for base ops (combinational, unchanged
//  encoding) and runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on an iterative
//  1-bit-per-cycle engine with valid/ready handshakes. Sits beside the ALU in the
//  multi-cycle datapath; the controller stalls on busy.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  reset        in   1     synchronous, active-high
//  part_of_inst in   32    full instruction word
//  rs1_data     in   XLEN  operand A (dividend / multiplicand)
//  rs2_data     in   XLEN  operand B (divisor / multiplier)
//  in_valid     in   1     operands + instruction valid
//  in_ready     out  1     engine can accept (state IDLE)
//  out_valid    out  1     out_result valid (state DONE)
//  out_ready    in   1     consumer takes result
//  out_result   out  XLEN  M-op result
//  is_muldiv    out  1     comb: opcode==7'b0110011 && inst[31:25]==7'b0000001
//  busy         out  1     state != IDLE
//  alu_op       out  11    comb base decode, see BEHAVIOUR
// BEHAVIOUR
//  alu_op (comb, independent of state): op=inst[6:0], f3=inst[14:12]
//   ARITHMETIC {inst[30],f3,op}; ARITHMETIC_IMM/BRANCH {0,f3,op}; LOAD {0,LW,op};
//   STORE {0,SW,op}; JALR {0,ADD,op}; other opcodes 0. M-ops also give {0,f3,op}.
//  Reset: state IDLE, out_valid=0, out_result=0, busy=0, in_ready=1, counters 0.
//  Accept = in_valid && in_ready && is_muldiv; non-M instructions never accepted.
//  FSM: IDLE -accept,normal-> CALC; IDLE -accept,special-> DONE;
//       CALC -iteration XLEN done-> DONE; DONE -out_ready-> IDLE; else hold.
//  Latency (accept in cycle 0): normal out_valid first high cycle XLEN+1;
//   special cases out_valid high cycle 1. No back-to-back: in_ready=0 in CALC/DONE.
//  Operands, f3 latched at accept; later input changes ignored.
//  Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU rs1 signed, rs2 unsigned;
//   MULHU/DIVU/REMU unsigned. Engine works on magnitudes, sign fix-up at end.
//  MUL -> low XLEN of 2*XLEN product; MULH* -> high XLEN.
//  DIV/REM truncate toward zero; REM sign = dividend sign.
//  Special cases (no iteration): divisor 0 -> DIV/DIVU all-ones, REM/REMU = rs1;
//   signed overflow DIV(-2^(XLEN-1), -1) -> -2^(XLEN-1), REM -> 0.
//   MUL with either operand 0 is NOT special (normal latency).
//  out_result stable while out_valid; holds last value in IDLE until next DONE.
//  out_valid && out_ready in same cycle: IDLE next cycle, in_ready 1 then.
//  Reset in any state: next cycle IDLE, out_valid=0, out_result=0; op discarded.
// TESTING  (XLEN=32)
//  MUL 7 x 0xFFFFFFFD, accept cyc 0 -> out_valid cyc 33, result 0xFFFFFFEB.
//  0xFFFFFFFF x 0xFFFFFFFF: MULHU->0xFFFFFFFE, MULH->0x00000000, MULHSU->0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC.
//  DIV 9/0 -> 0xFFFFFFFF cyc 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF
//   -> 0x80000000, REM -> 0, both cyc 1.
//  out_ready low 5 cycles in DONE -> result/out_valid held, in_ready 0, new
//   in_valid ignored; out_ready high -> IDLE next cycle.
//  reset in CALC cyc 10 -> cyc 11 IDLE, out_valid 0; ADD (0x00000033) with
//   in_valid -> not accepted, alu_op 0x033; SUB (0x40000033) -> alu_op 0x433.

Source files
------------

// File: rtl/muldiv_alu_control.sv
// RV32M-capable ALU control: combinational base alu_op decode plus an iterative mul/div engine.
// Latency: alu_op/is_muldiv combinational; M-ops XLEN+1 cycles, divide-by-zero/overflow 1 cycle.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
module muldiv_alu_control #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     part_of_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            is_muldiv,
  output logic            busy,
  output logic [10:0]     alu_op
);

  localparam int CW = $clog2(XLEN);

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_SW     = 3'b010;
  localparam logic [2:0] F3_ADD    = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  assign opcode = part_of_inst[6:0];
  assign f3     = part_of_inst[14:12];

  // Register fields are never needed here; gathered so lint sees them consumed.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{part_of_inst[24:15], part_of_inst[11:7]};

  // State and datapath registers.
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] wide_q, wide_d;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]        f3_q, f3_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Base decode: independent of the engine state.
  always_comb begin
    alu_op = '0;
    unique case (opcode)
      OP_ARITH:          alu_op = {part_of_inst[30], f3, opcode};
      OP_IMM, OP_BRANCH: alu_op = {1'b0, f3, opcode};
      OP_LOAD:           alu_op = {1'b0, F3_LW, opcode};
      OP_STORE:          alu_op = {1'b0, F3_SW, opcode};
      OP_JALR:           alu_op = {1'b0, F3_ADD, opcode};
      default:           alu_op = '0;
    endcase
  end

  assign is_muldiv = (opcode == OP_ARITH) && (part_of_inst[31:25] == 7'b0000001);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_result = result_q;

  // Operand preparation at accept: signedness, magnitudes and the no-iteration cases.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic            accept;

  always_comb begin
    // MULHU, DIVU, REMU treat rs1 as unsigned; only MUL/MULH/DIV/REM treat rs2 as signed.
    a_signed = !((f3 == 3'b011) || (f3 == 3'b101) || (f3 == 3'b111));
    b_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? (XLEN'(0) - rs1_data) : rs1_data;
    b_mag    = b_neg ? (XLEN'(0) - rs2_data) : rs2_data;
    div_zero = f3[2] && (rs2_data == '0);
    div_ovf  = ((f3 == 3'b100) || (f3 == 3'b110))
               && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2_data == '1);
    // f3[1] selects the remainder flavour of the divide ops.
    if (div_zero) begin
      special_res = f3[1] ? rs1_data : '1;
    end else begin
      special_res = f3[1] ? '0 : rs1_data;
    end
    accept = in_valid && in_ready && is_muldiv;
  end

  // One engine step: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] wide_step, prod;
  logic [XLEN-1:0]   quo, rem, res_fin;

  always_comb begin
    mul_sum  = {1'b0, wide_q[2*XLEN-1:XLEN]} + (wide_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {wide_q[2*XLEN-1:XLEN], wide_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ok   = !div_diff[XLEN];
    if (f3_q[2]) begin
      wide_step = div_ok ? {div_diff[XLEN-1:0], wide_q[XLEN-2:0], 1'b1}
                         : {div_sh[XLEN-1:0],   wide_q[XLEN-2:0], 1'b0};
    end else begin
      wide_step = {mul_sum, wide_q[XLEN-1:1]};
    end
    // Sign fix-up on the final magnitudes; unsigned ops never carry a negative flag.
    prod = (a_neg_q ^ b_neg_q) ? ((2*XLEN)'(0) - wide_step) : wide_step;
    quo  = wide_step[XLEN-1:0];
    rem  = wide_step[2*XLEN-1:XLEN];
    if (!f3_q[2]) begin
      res_fin = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (f3_q[1]) begin
      res_fin = a_neg_q ? (XLEN'(0) - rem) : rem;
    end else begin
      res_fin = (a_neg_q ^ b_neg_q) ? (XLEN'(0) - quo) : quo;
    end
  end

  // Next-state and register updates for the engine FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wide_d   = wide_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d    = f3;
          a_neg_d = a_neg;
          b_neg_d = b_neg;
          cnt_d   = '0;
          opnd_d  = f3[2] ? b_mag : a_mag;
          wide_d  = {{XLEN{1'b0}}, (f3[2] ? a_mag : b_mag)};
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        wide_d = wide_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          cnt_d    = '0;
          result_d = res_fin;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wide_q   <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wide_q   <= wide_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
    end
  end

endmodule
